pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter PC_W, default 32: PC width in bits, minimum 8.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_0080: PC value loaded on an exception.
REQ-004 Parameter RAS_DEPTH, default 8: return-address-stack entries; power of 2, 2..32.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 stall  in  1  freeze PC and RAS.
REQ-008 exc_valid  in  1  exception; load EXC_VEC.
REQ-009 redirect_valid  in  1  branch or jump resolved; load redirect_pc.
REQ-010 redirect_pc  in  PC_W  redirect target.
REQ-011 call_push  in  1  current instruction is a call; push pc+4.
REQ-012 ret_pop  in  1  current instruction is a predicted return; fetch from RAS top.
REQ-013 pc  out  PC_W  current fetch address, registered.
REQ-014 pc_valid  out  1  pc holds a valid fetch address.
REQ-015 misalign_err  out  1  one-cycle pulse: the last accepted redirect was misaligned.
REQ-016 ras_underflow  out  1  one-cycle pulse: pop requested while the RAS was empty.
REQ-017 ras_empty / ras_full  out  1 each  RAS occupancy flags, derived from the registered count.

Function
REQ-018 On the first rising edge after rst deasserts, pc_valid SHALL go to 1 and pc SHALL stay at RESET_VEC; all other inputs are ignored on that edge.
REQ-019 Once pc_valid=1, the next-PC priority SHALL be: exc_valid > redirect_valid > stall (hold) > ret_pop with RAS non-empty (RAS top) > sequential (pc+4).
REQ-020 exc_valid and redirect_valid SHALL override stall, giving flush semantics.
REQ-021 The sequential increment SHALL be pc+4 modulo 2^PC_W, so 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-022 If an accepted redirect has redirect_pc[1:0]!=0, pc SHALL load {redirect_pc[PC_W-1:2],2'b00} and misalign_err SHALL pulse high on the following cycle.
REQ-023 While stall=1 and neither exc_valid nor redirect_valid is high, pc and RAS state SHALL hold, and call_push and ret_pop SHALL be ignored.
REQ-024 call_push, when not blocked, SHALL push pc+4; when the RAS is full, the push SHALL overwrite the oldest entry (circular) and the count SHALL stay at RAS_DEPTH.
REQ-025 ret_pop with count>0, when it is the selected source, SHALL load pc from the top entry and decrement the count.
REQ-026 ret_pop with count=0 SHALL produce sequential pc+4 and pulse ras_underflow for one cycle.
REQ-027 call_push and ret_pop together with count>0 SHALL load pc from the top entry, then replace the top entry with the old pc+4; the count is unchanged.
REQ-028 call_push and ret_pop together with count=0 SHALL produce sequential pc+4, push the old pc+4, and pulse ras_underflow.
REQ-029 exc_valid SHALL clear the RAS count to 0; any call_push or ret_pop in the same cycle SHALL be ignored.
REQ-030 redirect_valid SHALL leave RAS contents intact, but call_push and ret_pop in the same cycle SHALL still update the RAS; pc takes the redirect target.
REQ-031 misalign_err and ras_underflow SHALL be registered and SHALL be low in every cycle not named in REQ-022, REQ-026 and REQ-028.

Reset
REQ-032 While rst=1: pc=RESET_VEC, pc_valid=0, misalign_err=0, ras_underflow=0, RAS count=0 (ras_empty=1, ras_full=0).
REQ-033 Reset asserted mid-operation SHALL take effect immediately (asynchronously) and discard all RAS contents and any pending flags.
REQ-034 RAS entry storage need not be reset; only the pointer and count are reset.

Structure
REQ-035 The default vectors, the instruction size (4) and the RAS depth default SHALL live in shared package pc_pkg.
REQ-036 The RAS (storage, top pointer, count, full/empty flags) SHALL be one sub-module, pc_ras, parametrised by PC_W and RAS_DEPTH.
REQ-037 The next-PC mux and the priority logic SHALL reside in pc_gen.

Verification
REQ-038 Reset, then release with no other inputs: pc=0x0 and pc_valid=1 after edge 1; pc=0x4 after edge 2; pc=0x8 after edge 3.
REQ-039 stall=1 for 3 cycles at pc=0x10 with redirect_valid=1, redirect_pc=0x200 in the 2nd cycle: pc=0x10, then 0x200 at the next edge, then 0x200 held while stall remains.
REQ-040 redirect_pc=0x103 accepted: pc=0x100 and misalign_err=1 for exactly one cycle.
REQ-041 call_push at pc=0x40, then redirect to 0x800, then ret_pop at pc=0x804: pc=0x44, ras_empty=1.
REQ-042 With RAS_DEPTH=8, issue 9 pushes followed by 9 pops: the first 8 pops return the 9 pushed values newest-first minus the oldest, and the 9th pop gives pc+4 with a ras_underflow pulse.
REQ-043 exc_valid with stall=1 and RAS count=3: pc=EXC_VEC and ras_empty=1 on the next edge; rst asserted mid-sequence gives pc=RESET_VEC and pc_valid=0 immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and encodings for the fetch PC generator and its return-address stack.
package pc_pkg;

  localparam int unsigned INSN_SIZE     = 4;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;
  localparam int unsigned DEF_RAS_DEPTH = 8;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } pc_state_e;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_EXC,
    SRC_REDIR,
    SRC_RAS,
    SRC_SEQ
  } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module pc_ras import pc_pkg::*; #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] nxt_ptr;
  logic [CNT_W-1:0] count;
  logic             replace_top;

  assign nxt_ptr     = top_ptr + PTR_W'(1);
  assign replace_top = push && pop && !empty;
  assign top_data    = mem[top_ptr];
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(RAS_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (replace_top) begin
      count <= count;
    end else if (push) begin
      top_ptr <= nxt_ptr;
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      top_ptr <= top_ptr - PTR_W'(1);
      count   <= count - CNT_W'(1);
    end
  end

  // Entry storage is deliberately unreset; only pointer and count matter.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (replace_top)
        mem[top_ptr] <= push_data;
      else if (push)
        mem[nxt_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised next-PC mux with exception, redirect, stall and RAS prediction.
//   state   | meaning
//   ST_INIT | first edge after reset; pc stays at RESET_VEC, pc_valid low
//   ST_RUN  | pc_valid high, next-PC mux active
module pc_gen import pc_pkg::*; #(
  parameter int unsigned      PC_W      = 32,
  parameter logic [PC_W-1:0]  RESET_VEC = PC_W'(DEF_RESET_VEC),
  parameter logic [PC_W-1:0]  EXC_VEC   = PC_W'(DEF_EXC_VEC),
  parameter int unsigned      RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            exc_valid,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            call_push,
  input  logic            ret_pop,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic            ras_underflow,
  output logic            ras_empty,
  output logic            ras_full
);

  pc_state_e       state, state_nxt;
  pc_src_e         src;
  logic [PC_W-1:0] pc_plus4, ras_top, next_pc;
  logic            ras_clear, ras_push, ras_pop, mis_d, unf_d;

  assign pc_plus4 = pc + PC_W'(INSN_SIZE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT) state_nxt = ST_RUN;
  end

  always_comb begin
    pc_valid = (state == ST_RUN);
  end

  // Exception and redirect both flush through a stall; only the exception kills the RAS.
  always_comb begin
    src       = SRC_HOLD;
    ras_clear = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    mis_d     = 1'b0;
    unf_d     = 1'b0;
    if (state == ST_RUN) begin
      if (exc_valid) begin
        src       = SRC_EXC;
        ras_clear = 1'b1;
      end else if (redirect_valid) begin
        src      = SRC_REDIR;
        mis_d    = |redirect_pc[1:0];
        ras_push = call_push;
        ras_pop  = ret_pop;
        unf_d    = ret_pop && ras_empty;
      end else if (!stall) begin
        if (ret_pop && !ras_empty) src = SRC_RAS;
        else                       src = SRC_SEQ;
        ras_push = call_push;
        ras_pop  = ret_pop;
        unf_d    = ret_pop && ras_empty;
      end
    end
  end

  always_comb begin
    next_pc = pc;
    case (src)
      SRC_EXC:   next_pc = EXC_VEC;
      SRC_REDIR: next_pc = {redirect_pc[PC_W-1:2], 2'b00};
      SRC_RAS:   next_pc = ras_top;
      SRC_SEQ:   next_pc = pc_plus4;
      default:   next_pc = pc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_VEC;
      misalign_err  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= next_pc;
      misalign_err  <= mis_d;
      ras_underflow <= unf_d;
    end
  end

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .clear     (ras_clear),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Directed and random checks of pc_gen against a queue-based behavioural model with a scoreboard.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, exc_valid = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        call_push = 1'b0, ret_pop = 1'b0;
  logic [31:0] pc;
  logic        pc_valid, misalign_err, ras_underflow, ras_empty, ras_full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        valid, mis, unf, empty, full;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_ras[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_valid = 1'b0, m_mis = 1'b0, m_unf = 1'b0;

  pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .exc_valid      (exc_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .call_push      (call_push),
    .ret_pop        (ret_pop),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .misalign_err   (misalign_err),
    .ras_underflow  (ras_underflow),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_unf = 1'b0;
    m_ras.delete();
  endtask

  task automatic ras_update(input logic [31:0] p4);
    if (call_push && ret_pop) begin
      if (m_ras.size() > 0) m_ras[m_ras.size()-1] = p4;
      else begin m_ras.push_back(p4); m_unf = 1'b1; end
    end else if (call_push) begin
      m_ras.push_back(p4);
      if (m_ras.size() > 8) void'(m_ras.pop_front());
    end else if (ret_pop) begin
      if (m_ras.size() > 0) void'(m_ras.pop_back());
      else m_unf = 1'b1;
    end
  endtask

  task automatic model_step();
    exp_t x;
    logic [31:0] p4 = m_pc + 32'd4;
    m_mis = 1'b0; m_unf = 1'b0;
    if (!m_valid) m_valid = 1'b1;
    else if (exc_valid) begin
      m_pc = 32'h80;
      m_ras.delete();
    end else if (redirect_valid) begin
      m_pc  = redirect_pc & 32'hFFFF_FFFC;
      m_mis = (redirect_pc[1:0] != 2'b00);
      ras_update(p4);
    end else if (!stall) begin
      if (ret_pop && m_ras.size() > 0) m_pc = m_ras[m_ras.size()-1];
      else                             m_pc = p4;
      ras_update(p4);
    end
    x.pc = m_pc; x.valid = m_valid; x.mis = m_mis; x.unf = m_unf;
    x.empty = (m_ras.size() == 0); x.full = (m_ras.size() == 8);
    sb.push_back(x);
  endtask

  task automatic compare_front();
    exp_t x;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    x = sb.pop_front();
    check("pc", pc, x.pc);
    check("pc_valid", {31'b0, pc_valid}, {31'b0, x.valid});
    check("misalign_err", {31'b0, misalign_err}, {31'b0, x.mis});
    check("ras_underflow", {31'b0, ras_underflow}, {31'b0, x.unf});
    check("ras_empty", {31'b0, ras_empty}, {31'b0, x.empty});
    check("ras_full", {31'b0, ras_full}, {31'b0, x.full});
  endtask

  task automatic step(input bit s, input bit e, input bit r, input logic [31:0] rp,
                      input bit cp, input bit rpop);
    stall = s; exc_valid = e; redirect_valid = r; redirect_pc = rp;
    call_push = cp; ret_pop = rpop;
    model_step();
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_valid"}, {31'b0, pc_valid}, 32'd0);
    check({tag, "_mis"}, {31'b0, misalign_err}, 32'd0);
    check({tag, "_unf"}, {31'b0, ras_underflow}, 32'd0);
    check({tag, "_empty"}, {31'b0, ras_empty}, 32'd1);
    check({tag, "_full"}, {31'b0, ras_full}, 32'd0);
  endtask

  initial begin
    // Power-on reset
    #1;
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Release: 0, 4, 8
    idle(); check("rel_pc1", pc, 32'h0); check("rel_valid1", {31'b0, pc_valid}, 32'd1);
    idle(); check("rel_pc2", pc, 32'h4);
    idle(); check("rel_pc3", pc, 32'h8);
    idle(); idle(); check("pre_stall_pc", pc, 32'h10);

    // Stall with flushing redirect in the second cycle
    step(1, 0, 0, 32'h0, 0, 0);   check("stall_hold", pc, 32'h10);
    step(1, 0, 1, 32'h200, 0, 0); check("stall_redir", pc, 32'h200);
    step(1, 0, 0, 32'h0, 0, 0);   check("stall_after_redir", pc, 32'h200);
    idle(); check("unstall_seq", pc, 32'h204);

    // Misaligned redirect
    step(0, 0, 1, 32'h103, 0, 0);
    check("misalign_pc", pc, 32'h100);
    check("misalign_pulse", {31'b0, misalign_err}, 32'd1);
    idle(); check("misalign_clear", {31'b0, misalign_err}, 32'd0);

    // Call, redirect, return
    step(0, 0, 1, 32'h40, 0, 0);
    step(0, 0, 0, 32'h0, 1, 0);  check("call_pc", pc, 32'h44);
    step(0, 0, 1, 32'h800, 0, 0);
    idle(); check("callee_pc", pc, 32'h804);
    step(0, 0, 0, 32'h0, 0, 1);
    check("ret_pc", pc, 32'h44);
    check("ret_empty", {31'b0, ras_empty}, 32'd1);

    // Nine pushes into an eight-deep stack, then nine pops
    for (int i = 0; i < 9; i++) step(0, 0, 0, 32'h0, 1, 0);
    check("overflow_full", {31'b0, ras_full}, 32'd1);
    for (int j = 0; j < 8; j++) begin
      step(0, 0, 0, 32'h0, 0, 1);
      check("pop_value", pc, 32'h48 + 32'(4 * (8 - j)));
    end
    step(0, 0, 0, 32'h0, 0, 1);
    check("pop9_pc", pc, 32'h50);
    check("pop9_underflow", {31'b0, ras_underflow}, 32'd1);
    idle(); check("underflow_clear", {31'b0, ras_underflow}, 32'd0);

    // Simultaneous push+pop: empty then non-empty
    step(0, 0, 0, 32'h0, 1, 1);
    check("pushpop_empty_pc", pc, 32'h58);
    check("pushpop_empty_unf", {31'b0, ras_underflow}, 32'd1);
    step(0, 0, 1, 32'h600, 0, 0);
    step(0, 0, 0, 32'h0, 1, 1);
    check("pushpop_top_pc", pc, 32'h58);
    step(0, 0, 0, 32'h0, 0, 1);
    check("pushpop_replaced", pc, 32'h604);

    // Wraparound of the sequential increment
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    idle(); check("wrap_pc", pc, 32'h0);

    // Exception under stall clears a three-deep stack
    step(0, 1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 1, 0);
    check("exc_pre_nonempty", {31'b0, ras_empty}, 32'd0);
    step(1, 1, 0, 32'h0, 1, 1);
    check("exc_pc", pc, 32'h80);
    check("exc_empty", {31'b0, ras_empty}, 32'd1);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(7) == 0,
           $urandom, $urandom_range(2) == 0, $urandom_range(2) == 0);
    end

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 1, 0);
    #2 rst = 1'b1;
    #1;
    check_reset_state("midreset");
    model_reset();
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(); check("post_reset_pc", pc, 32'h0);
    idle(); check("post_reset_seq", pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
